// File: rtl/exe_pkg.sv
// Shared types and constants for the exe_unit_pipe execution unit.
//   op_e     : 2-bit operation code (sub, compare, shift-left, bit-toggle)
//   ST_*     : bit positions inside the 4-bit status word
//   s1_ctl_t : control half of the S1 operand beat; the operands sit next to
//              it in the top because their width follows the BITS parameter.
package exe_pkg;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_CMP = 2'b01,
        OP_SHL = 2'b10,
        OP_TGL = 2'b11
    } op_e;

    localparam int ST_OVF    = 0;
    localparam int ST_SINGLE = 1;
    localparam int ST_EVEN   = 2;
    localparam int ST_ERR    = 3;

    typedef struct packed {
        op_e  op;
        logic acc;
    } s1_ctl_t;

endpackage

// File: rtl/exe_alu_core.sv
// Combinational ALU core placed between the S1 operand stage and the S2
// result stage.
//   a, b   : effective operands (a already muxed with the accumulator)
//   op     : operation code
//   out    : result
//   status : {ERROR, EVEN, SINGLE, OVF}, flags derived from out's zero count
module exe_alu_core
    import exe_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  op_e             op,
    output logic [BITS-1:0] out,
    output logic [3:0]      status
);

    localparam int             ZW     = $clog2(BITS + 1);
    localparam logic [BITS:0]  BITS_V = (BITS + 1)'(BITS);

    logic                  b_big;
    logic [2*BITS-1:0]     shl_wide;
    logic [BITS-1:0]       bit_mask;
    logic                  ovf;
    logic                  err;
    logic [ZW-1:0]         zeros;

    // Shift/toggle amounts at or beyond the width are reported as errors.
    assign b_big    = {1'b0, b} >= BITS_V;
    // Double-width shift keeps the bits pushed past the MSB for the OVF flag.
    assign shl_wide = {{BITS{1'b0}}, a} << b;
    assign bit_mask = {{(BITS-1){1'b0}}, 1'b1} << b;

    always_comb begin
        out = '0;
        ovf = 1'b0;
        err = 1'b0;
        case (op)
            OP_SUB: begin
                out = a - b;
                ovf = a < b;
            end
            OP_CMP: begin
                out = {{(BITS-1){1'b0}}, a > b};
            end
            OP_SHL: begin
                if (b_big) begin
                    err = 1'b1;
                end else begin
                    out = shl_wide[BITS-1:0];
                    ovf = |shl_wide[2*BITS-1:BITS];
                end
            end
            OP_TGL: begin
                if (b_big) begin
                    out = a;
                    err = 1'b1;
                end else begin
                    out = a ^ bit_mask;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        zeros = '0;
        for (int i = 0; i < BITS; i++) begin
            zeros = zeros + {{(ZW-1){1'b0}}, ~out[i]};
        end
    end

    always_comb begin
        status            = '0;
        status[ST_ERR]    = err;
        status[ST_EVEN]   = ~zeros[0];
        status[ST_SINGLE] = (zeros == ZW'(1));
        status[ST_OVF]    = ovf;
    end

endmodule

// File: rtl/exe_unit_pipe.sv
// Two-stage elastic execution unit with valid/ready on both sides.
//   i_clk, i_rst      : clock, asynchronous active-low reset
//   in_a, in_b, i_op  : operand beat; i_acc selects the last result as A
//   i_valid / o_ready : upstream handshake (o_ready is combinational)
//   o_out, o_status   : result and {ERROR, EVEN, SINGLE, OVF} from S2
//   o_valid / i_ready : downstream handshake
//   o_err_cnt         : saturating count of delivered results with ERROR set
module exe_unit_pipe
    import exe_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int CNT_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [BITS-1:0]   in_a,
    input  logic [BITS-1:0]   in_b,
    input  logic [1:0]        i_op,
    input  logic              i_acc,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [BITS-1:0]   o_out,
    output logic [3:0]        o_status,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CNT_W-1:0]  o_err_cnt
);

    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    logic              s1_valid_q, s1_valid_d;
    logic [BITS-1:0]   s1_a_q,     s1_a_d;
    logic [BITS-1:0]   s1_b_q,     s1_b_d;
    s1_ctl_t           s1_ctl_q,   s1_ctl_d;
    logic              s2_valid_q, s2_valid_d;
    logic [BITS-1:0]   s2_out_q,   s2_out_d;
    logic [3:0]        s2_st_q,    s2_st_d;
    logic [BITS-1:0]   acc_q,      acc_d;
    logic [CNT_W-1:0]  err_cnt_q,  err_cnt_d;

    logic              s2_adv;
    logic              accept;
    logic              xfer;
    logic [BITS-1:0]   op_a;
    logic [BITS-1:0]   alu_out;
    logic [3:0]        alu_st;

    assign s2_adv  = !s2_valid_q || i_ready;
    assign o_ready = !s1_valid_q || s2_adv;
    assign accept  = i_valid && o_ready;
    assign xfer    = s1_valid_q && s2_adv;

    // The accumulator is refreshed on every S1->S2 move, so a following
    // accumulate beat already sitting in S1 sees it on the next cycle.
    assign op_a = s1_ctl_q.acc ? acc_q : s1_a_q;

    exe_alu_core #(.BITS(BITS)) u_alu (
        .a      (op_a),
        .b      (s1_b_q),
        .op     (s1_ctl_q.op),
        .out    (alu_out),
        .status (alu_st)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_ctl_d   = s1_ctl_q;
        s2_valid_d = s2_valid_q;
        s2_out_d   = s2_out_q;
        s2_st_d    = s2_st_q;
        acc_d      = acc_q;
        err_cnt_d  = err_cnt_q;

        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_a_d       = in_a;
            s1_b_d       = in_b;
            s1_ctl_d.op  = op_e'(i_op);
            s1_ctl_d.acc = i_acc;
        end else if (xfer) begin
            s1_valid_d = 1'b0;
        end

        if (xfer) begin
            s2_valid_d = 1'b1;
            s2_out_d   = alu_out;
            s2_st_d    = alu_st;
            acc_d      = alu_out;
        end else if (i_ready) begin
            s2_valid_d = 1'b0;
        end

        if (s2_valid_q && i_ready && s2_st_q[ST_ERR] && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_ctl_q   <= '{op: OP_SUB, acc: 1'b0};
            s2_valid_q <= 1'b0;
            s2_out_q   <= '0;
            s2_st_q    <= '0;
            acc_q      <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_ctl_q   <= s1_ctl_d;
            s2_valid_q <= s2_valid_d;
            s2_out_q   <= s2_out_d;
            s2_st_q    <= s2_st_d;
            acc_q      <= acc_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_valid   = s2_valid_q;
    assign o_out     = s2_out_q;
    assign o_status  = s2_st_q;
    assign o_err_cnt = err_cnt_q;

endmodule
